// File: rtl/uart_host_sequencer.sv
// Bus-side initiator for the UART core: TX bytes become one-cycle write strobes, RXRDY polls become read strobes into a local RX FIFO.
// TX byte reaches the UART one cycle after acceptance; a full RX FIFO stalls reads and the UART keeps holding its byte.
module uart_host_sequencer #(
  parameter int RX_DEPTH = 16,
  parameter int HOLDOFF  = 3
) (
  input  logic       CLK,
  input  logic       aresetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       ovf_seen,
  input  logic       clr_status,
  output logic       uart_csn,
  output logic       uart_wen,
  output logic       uart_oen,
  output logic [7:0] uart_din,
  input  logic       uart_txrdy,
  input  logic       uart_rxrdy,
  input  logic [7:0] uart_dout,
  input  logic       uart_perr,
  input  logic       uart_ferr,
  input  logic       uart_ovf
);

  localparam int             AW        = $clog2(RX_DEPTH);
  localparam int             PW        = AW + 1;
  localparam logic [3:0]     HOLD_LOAD = 4'(HOLDOFF - 1);
  localparam logic [PW-1:0]  DEPTH_P   = PW'(RX_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_STB, RD_STB, HOLD} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_rx_q, last_rx_d;
  logic [7:0]    din_q, din_d;
  logic          csn_q, wen_q, oen_q;
  logic          ovf_q, ovf_d;
  logic          ovf_set;
  logic          push, pop;
  logic          rd_req, wr_req;

  logic [9:0]    mem_q [RX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] count;
  logic [9:0]    head;

  assign count  = wr_ptr_q - rd_ptr_q;
  assign rd_req = uart_rxrdy & (count < DEPTH_P);
  assign wr_req = tx_valid & uart_txrdy;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rx_d = last_rx_q;
    din_d     = din_q;
    tx_ready  = 1'b0;
    push      = 1'b0;
    ovf_set   = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the grant alternates; after reset RX wins first.
        if (rd_req && (!wr_req || !last_rx_q)) begin
          state_d   = RD_STB;
          last_rx_d = 1'b1;
        end else if (wr_req) begin
          state_d   = WR_STB;
          last_rx_d = 1'b0;
          tx_ready  = 1'b1;
          din_d     = tx_data;
        end
      end
      WR_STB, RD_STB: begin
        if (state_q == RD_STB) begin
          push    = 1'b1;
          ovf_set = uart_ovf;
        end
        if (HOLDOFF == 1) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        // Exiting at count 1 leaves IDLE as the last quiet cycle before the next strobe.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_d = ovf_set ? 1'b1 : (clr_status ? 1'b0 : ovf_q);
  assign pop   = rx_valid & rx_ready;

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_rx_q <= 1'b0;
      din_q     <= 8'd0;
      csn_q     <= 1'b1;
      wen_q     <= 1'b1;
      oen_q     <= 1'b1;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rx_q <= last_rx_d;
      din_q     <= din_d;
      csn_q     <= !((state_d == WR_STB) || (state_d == RD_STB));
      wen_q     <= !(state_d == WR_STB);
      oen_q     <= !(state_d == RD_STB);
      ovf_q     <= ovf_d;
      if (push) wr_ptr_q <= PW'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_q <= PW'(rd_ptr_q + 1'b1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {uart_perr, uart_ferr, uart_dout};
  end

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_valid = (count != '0);
  // Outputs are forced to zero while empty so reset and drained states read cleanly.
  assign {rx_perr, rx_ferr, rx_data} = rx_valid ? head : 10'd0;

  assign ovf_seen = ovf_q;
  assign uart_csn = csn_q;
  assign uart_wen = wen_q;
  assign uart_oen = oen_q;
  assign uart_din = din_q;

endmodule
